// File: rtl/glyph_drop_anim.sv
// Title-glyph animator: drops the glyph origin from Y_START to Y_TARGET, holds it, blinks it, then leaves it shown.
// Origin and enable move only on frame_tick. stop overrides start, and start overrides frame_tick.
module glyph_drop_anim #(
  parameter int unsigned X_POS        = 288,
  parameter int unsigned Y_START      = 0,
  parameter int unsigned Y_TARGET     = 200,
  parameter int unsigned STEP         = 4,
  parameter int unsigned HOLD_FRAMES  = 120,
  parameter int unsigned BLINK_PERIOD = 16,
  parameter int unsigned BLINK_COUNT  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       stop,
  output logic [9:0] x0,
  output logic [9:0] y0,
  output logic       en,
  output logic       busy,
  output logic       done
);

  localparam int unsigned FC_MAX  = (HOLD_FRAMES > BLINK_PERIOD) ? HOLD_FRAMES : BLINK_PERIOD;
  localparam int unsigned FCW     = $clog2(FC_MAX + 1);
  localparam int unsigned TOGGLES = 2 * BLINK_COUNT;
  localparam int unsigned TCW     = $clog2(TOGGLES + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DROP  = 3'd1,
    S_HOLD  = 3'd2,
    S_BLINK = 3'd3,
    S_SHOW  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [9:0]       y_q, y_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [FCW-1:0]   fcnt_q, fcnt_d;
  logic [TCW-1:0]   tcnt_q, tcnt_d;

  // The drop step is evaluated in 11 bits, so overshooting the target can never wrap the row.
  logic [10:0]      y_step;
  logic             drop_end;
  logic [FCW-1:0]   fcnt_inc;
  logic [TCW-1:0]   tcnt_inc;
  logic             hold_end;
  logic             half_end;
  logic             blink_end;

  assign y_step    = {1'b0, y_q} + 11'(STEP);
  assign drop_end  = (y_step >= 11'(Y_TARGET));
  assign fcnt_inc  = fcnt_q + FCW'(1);
  assign tcnt_inc  = tcnt_q + TCW'(1);
  assign hold_end  = (fcnt_inc == FCW'(HOLD_FRAMES));
  assign half_end  = (fcnt_inc == FCW'(BLINK_PERIOD));
  assign blink_end = half_end && (tcnt_inc == TCW'(TOGGLES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      y_q     <= 10'(Y_START);
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fcnt_q  <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fcnt_q  <= fcnt_d;
      tcnt_q  <= tcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start) state_d = S_DROP;
        S_DROP:  if (frame_tick && drop_end) state_d = S_HOLD;
        S_HOLD:  if (frame_tick && hold_end) state_d = S_BLINK;
        S_BLINK: if (frame_tick && blink_end) state_d = S_SHOW;
        S_SHOW:  if (start) state_d = S_DROP;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    y_d    = y_q;
    en_d   = en_q;
    busy_d = busy_q;
    done_d = 1'b0;
    fcnt_d = fcnt_q;
    tcnt_d = tcnt_q;
    if (stop) begin
      y_d    = 10'(Y_START);
      en_d   = 1'b0;
      busy_d = 1'b0;
      fcnt_d = '0;
      tcnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE, S_SHOW: begin
          // A start that coincides with a frame_tick only arms the drop; movement begins on the next tick.
          if (start) begin
            y_d    = 10'(Y_START);
            en_d   = 1'b1;
            busy_d = 1'b1;
            fcnt_d = '0;
            tcnt_d = '0;
          end
        end
        S_DROP: begin
          if (frame_tick) begin
            if (drop_end) begin
              y_d    = 10'(Y_TARGET);
              fcnt_d = '0;
            end else begin
              y_d = y_step[9:0];
            end
          end
        end
        S_HOLD: begin
          if (frame_tick) begin
            if (hold_end) begin
              fcnt_d = '0;
              tcnt_d = '0;
            end else begin
              fcnt_d = fcnt_inc;
            end
          end
        end
        S_BLINK: begin
          if (frame_tick) begin
            if (half_end) begin
              en_d   = ~en_q;
              fcnt_d = '0;
              tcnt_d = tcnt_inc;
              if (blink_end) begin
                busy_d = 1'b0;
                done_d = 1'b1;
                tcnt_d = '0;
              end
            end else begin
              fcnt_d = fcnt_inc;
            end
          end
        end
        default: begin
          y_d    = 10'(Y_START);
          en_d   = 1'b0;
          busy_d = 1'b0;
        end
      endcase
    end
  end

  assign x0   = 10'(X_POS);
  assign y0   = y_q;
  assign en   = en_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_glyph_drop_anim.sv
// Bench for glyph_drop_anim with a short animation: target row 10, step 4, hold 2 frames, blink period 2, one blink pair.
// Each cycle pushes its expected outputs into a queue and pops them after the clock edge.
module tb_glyph_drop_anim;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [9:0] x0, y0;
  logic       en, busy, done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       st, sp, tk;
    logic [9:0] y;
    logic       en, busy, done;
  } vec_t;

  typedef struct {
    logic [9:0] y;
    logic       en, busy, done;
    int         id;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[21];

  glyph_drop_anim #(
    .X_POS(288), .Y_START(0), .Y_TARGET(10), .STEP(4),
    .HOLD_FRAMES(2), .BLINK_PERIOD(2), .BLINK_COUNT(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .start(start), .stop(stop),
    .x0(x0), .y0(y0), .en(en), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%0d want=%0d", nm, id, act, exp);
    end
  endtask

  // Drive one cycle of stimulus from a negedge, then check the outputs just after the next posedge.
  task automatic step(input logic st, input logic sp, input logic tk,
                      input logic [9:0] ey, input logic een, input logic eb, input logic ed,
                      input int id);
    exp_t e;
    start = st; stop = sp; frame_tick = tk;
    sb.push_back('{ey, een, eb, ed, id});
    @(posedge clk);
    #1;
    start = 1'b0; stop = 1'b0; frame_tick = 1'b0;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", id, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("y0",   e.id, 32'(y0),   32'(e.y));
      chk("en",   e.id, 32'(en),   32'(e.en));
      chk("busy", e.id, 32'(busy), 32'(e.busy));
      chk("done", e.id, 32'(done), 32'(e.done));
      chk("x0",   e.id, 32'(x0),   32'd288);
    end
    @(negedge clk);
  endtask

  initial begin
    //         st  sp  tk   y   en  busy done
    tbl[0]  = '{0, 0, 1, 10'd0,  0, 0, 0};  // IDLE ignores frame_tick
    tbl[1]  = '{1, 0, 0, 10'd0,  1, 1, 0};  // start -> DROP
    tbl[2]  = '{0, 0, 1, 10'd4,  1, 1, 0};
    tbl[3]  = '{0, 0, 1, 10'd8,  1, 1, 0};
    tbl[4]  = '{0, 0, 1, 10'd10, 1, 1, 0};  // saturates at the target, HOLD
    tbl[5]  = '{0, 0, 0, 10'd10, 1, 1, 0};
    tbl[6]  = '{1, 0, 0, 10'd10, 1, 1, 0};  // start in HOLD ignored
    tbl[7]  = '{0, 0, 1, 10'd10, 1, 1, 0};
    tbl[8]  = '{0, 0, 1, 10'd10, 1, 1, 0};  // -> BLINK
    tbl[9]  = '{0, 0, 1, 10'd10, 1, 1, 0};
    tbl[10] = '{0, 0, 1, 10'd10, 0, 1, 0};  // first toggle 1->0
    tbl[11] = '{0, 0, 1, 10'd10, 0, 1, 0};
    tbl[12] = '{0, 0, 1, 10'd10, 1, 0, 1};  // second toggle -> SHOW, done pulse
    tbl[13] = '{0, 0, 0, 10'd10, 1, 0, 0};
    tbl[14] = '{0, 0, 1, 10'd10, 1, 0, 0};  // SHOW ignores frame_tick
    tbl[15] = '{1, 0, 1, 10'd0,  1, 1, 0};  // start+tick in SHOW: restart, no movement
    tbl[16] = '{0, 0, 1, 10'd4,  1, 1, 0};
    tbl[17] = '{1, 1, 0, 10'd0,  0, 0, 0};  // stop beats start
    tbl[18] = '{1, 0, 1, 10'd0,  1, 1, 0};  // start+tick in IDLE
    tbl[19] = '{0, 0, 0, 10'd0,  1, 1, 0};
    tbl[20] = '{0, 0, 1, 10'd4,  1, 1, 0};

    #3;
    chk("rst_y0",   -1, 32'(y0),   32'd0);
    chk("rst_x0",   -1, 32'(x0),   32'd288);
    chk("rst_en",   -1, 32'(en),   32'd0);
    chk("rst_busy", -1, 32'(busy), 32'd0);
    chk("rst_done", -1, 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 21; i++) begin
      step(tbl[i].st, tbl[i].sp, tbl[i].tk, tbl[i].y, tbl[i].en, tbl[i].busy, tbl[i].done, i);
    end

    // stop on the edge that would enter SHOW: done must stay low
    step(0, 0, 1, 10'd8,  1, 1, 0, 100);
    step(0, 0, 1, 10'd10, 1, 1, 0, 101);
    step(0, 0, 1, 10'd10, 1, 1, 0, 102);
    step(0, 0, 1, 10'd10, 1, 1, 0, 103);
    step(0, 0, 1, 10'd10, 1, 1, 0, 104);
    step(0, 0, 1, 10'd10, 0, 1, 0, 105);
    step(0, 0, 1, 10'd10, 0, 1, 0, 106);
    step(0, 1, 1, 10'd0,  0, 0, 0, 107);
    step(0, 0, 0, 10'd0,  0, 0, 0, 108);

    // asynchronous reset in the middle of BLINK, sampled with no clock edge in between
    step(1, 0, 0, 10'd0,  1, 1, 0, 200);
    step(0, 0, 1, 10'd4,  1, 1, 0, 201);
    step(0, 0, 1, 10'd8,  1, 1, 0, 202);
    step(0, 0, 1, 10'd10, 1, 1, 0, 203);
    step(0, 0, 1, 10'd10, 1, 1, 0, 204);
    step(0, 0, 1, 10'd10, 1, 1, 0, 205);
    step(0, 0, 1, 10'd10, 1, 1, 0, 206);
    step(0, 0, 1, 10'd10, 0, 1, 0, 207);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_y0",   300, 32'(y0),   32'd0);
    chk("arst_x0",   300, 32'(x0),   32'd288);
    chk("arst_en",   300, 32'(en),   32'd0);
    chk("arst_busy", 300, 32'(busy), 32'd0);
    chk("arst_done", 300, 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    step(0, 0, 1, 10'd0, 0, 0, 0, 301);

    chk("scoreboard_drained", 400, 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
